// File: rtl/sound_sequencer.sv
// sound_sequencer: plays short fixed melodies from an internal note ROM as a
// square wave, triggered by cue requests from the level state machine.
//
// Ports:
//   clk           system clock (table half-periods assume 50 MHz)
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse per video frame; note durations count these
//   sound_request cue code: 1=Win 2=Loss 3=Claw 4=Gold 5=Stone
//   play_sound    one-cycle strobe qualifying sound_request
//   mute          gates tone_out low without disturbing sequencing
//   tone_out      square-wave audio output
//   sound_busy    high while a melody is loaded or playing (registered)
//   active_sound  code of the melody in progress, 0 when idle (registered)
module sound_sequencer #(
    parameter int MAX_NOTES = 4,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] sound_request,
    input  logic       play_sound,
    input  logic       mute,
    output logic       tone_out,
    output logic       sound_busy,
    output logic [3:0] active_sound
);

    localparam int IDX_W = $clog2(MAX_NOTES + 1);

    typedef enum logic [1:0] {IDLE_ST, LOAD_ST, PLAY_ST} state_t;

    typedef struct packed {
        logic [2:0] note;
        logic [4:0] dur;
    } rom_entry_t;

    state_t             state, next_state;
    logic [3:0]         active_q;
    logic               busy_q;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   half_period;
    logic [CNT_W-1:0]   tone_cnt;
    logic [7:0]         frame_cnt;
    logic               tone_q;
    logic               rest_q;

    // Melody ROM: {note, frames}; a zero duration ends the melody early.
    function automatic rom_entry_t rom(input logic [3:0] code, input logic [IDX_W-1:0] i);
        rom_entry_t e;
        e = '0;
        case (code)
            4'd1: case (i)
                IDX_W'(0): e = '{3'd4, 5'd6};
                IDX_W'(1): e = '{3'd5, 5'd6};
                IDX_W'(2): e = '{3'd6, 5'd6};
                IDX_W'(3): e = '{3'd7, 5'd12};
                default:   e = '0;
            endcase
            4'd2: case (i)
                IDX_W'(0): e = '{3'd6, 5'd8};
                IDX_W'(1): e = '{3'd5, 5'd8};
                IDX_W'(2): e = '{3'd4, 5'd8};
                IDX_W'(3): e = '{3'd1, 5'd16};
                default:   e = '0;
            endcase
            4'd3: if (i == IDX_W'(0)) e = '{3'd3, 5'd4};
            4'd4: case (i)
                IDX_W'(0): e = '{3'd5, 5'd3};
                IDX_W'(1): e = '{3'd7, 5'd6};
                default:   e = '0;
            endcase
            4'd5: case (i)
                IDX_W'(0): e = '{3'd1, 5'd4};
                IDX_W'(1): e = '{3'd2, 5'd4};
                default:   e = '0;
            endcase
            default: e = '0;
        endcase
        return e;
    endfunction

    // Half-period in clk cycles per note; 0 marks a rest.
    function automatic logic [CNT_W-1:0] note_hp(input logic [2:0] n);
        case (n)
            3'd1:    return CNT_W'(95420);
            3'd2:    return CNT_W'(71633);
            3'd3:    return CNT_W'(56818);
            3'd4:    return CNT_W'(47801);
            3'd5:    return CNT_W'(37936);
            3'd6:    return CNT_W'(31888);
            3'd7:    return CNT_W'(23889);
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] prio(input logic [3:0] code);
        case (code)
            4'd1, 4'd2: return 2'd2;
            4'd4, 4'd5: return 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

    logic       code_ok;
    logic       accept;
    rom_entry_t cur;
    logic       melody_end;

    assign code_ok    = (sound_request >= 4'd1) && (sound_request <= 4'd5);
    assign accept     = play_sound && code_ok &&
                        ((state == IDLE_ST) || (prio(sound_request) >= prio(active_q)));
    assign cur        = rom(active_q, idx);
    assign melody_end = (idx == IDX_W'(MAX_NOTES)) || (cur.dur == 5'd0);

    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = LOAD_ST;
        end else begin
            case (state)
                LOAD_ST: next_state = melody_end ? IDLE_ST : PLAY_ST;
                PLAY_ST: if (startOfFrame && frame_cnt == 8'd1) next_state = LOAD_ST;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE_ST;
            active_q    <= '0;
            busy_q      <= 1'b0;
            idx         <= '0;
            half_period <= '0;
            tone_cnt    <= '0;
            frame_cnt   <= '0;
            tone_q      <= 1'b0;
            rest_q      <= 1'b1;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE_ST);

            // Tone generator free-runs through the whole PLAY_ST cycle,
            // including one where a new request or note change lands.
            if (state == PLAY_ST) begin
                if (tone_cnt == half_period - CNT_W'(1)) begin
                    tone_cnt <= '0;
                    if (!rest_q) tone_q <= ~tone_q;
                end else begin
                    tone_cnt <= tone_cnt + CNT_W'(1);
                end
            end

            // An accepted request overrides any frame decrement this cycle.
            if (accept) begin
                active_q <= sound_request;
                idx      <= '0;
            end else begin
                case (state)
                    LOAD_ST: begin
                        if (melody_end) begin
                            active_q <= '0;
                            idx      <= '0;
                            tone_q   <= 1'b0;
                        end else begin
                            half_period <= note_hp(cur.note);
                            rest_q      <= (cur.note == 3'd0);
                            frame_cnt   <= {3'b000, cur.dur};
                            tone_cnt    <= '0;
                            tone_q      <= 1'b0;
                        end
                    end
                    PLAY_ST: begin
                        if (startOfFrame) begin
                            frame_cnt <= frame_cnt - 8'd1;
                            if (frame_cnt == 8'd1) idx <= idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tone_out     = tone_q & ~mute;
    assign sound_busy   = busy_q;
    assign active_sound = active_q;

endmodule
